// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that writes 32-bit words into instruction memory
//
// Purpose:
//   Takes bytes over a valid/ready handshake. Packs each group of four bytes
//   into one little-endian instruction word. Writes each word with a
//   single-cycle pulse on the instruction memory write port. The CPU is held
//   for the whole load session.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset, priority over everything
//   start       begin a session (sampled in IDLE only)
//   num_words   number of words to load, clamped to memory depth
//   byte_valid  byte_data is valid
//   byte_data   next byte, least significant byte of each word first
//   byte_ready  loader accepts a byte this cycle
//   we          one-cycle write enable per word
//   wa          word-aligned byte write address
//   wd          write data
//   cpu_hold    CPU must stall while high
//   busy        session in progress
//   done        one-cycle pulse at session end
module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INS_ADDRESS-2:0] num_words,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   we,
    output logic [INS_ADDRESS-1:0] wa,
    output logic [INS_W-1:0]       wd,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH_W = INS_ADDRESS - 2;
    localparam int CNT_W   = INS_ADDRESS - 1;
    localparam logic [CNT_W-1:0] DEPTH   = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [DEPTH_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    // Only bytes 0..2 are staged; byte 3 is merged straight into wd.
    logic [23:0]          asm_q, asm_d;
    logic [INS_ADDRESS-1:0] wa_q, wa_d;
    logic [INS_W-1:0]     wd_q, wd_d;
    logic [CNT_W-1:0]     clamped;

    assign clamped = (num_words > DEPTH) ? DEPTH : num_words;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        asm_d   = asm_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = clamped;
                    addr_d  = '0;
                    idx_d   = '0;
                    state_d = (clamped == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (byte_valid) begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: begin
                            // Word complete: latch address/data so they are
                            // stable during WRITE and hold afterwards.
                            wa_d    = {addr_q, 2'b00};
                            wd_d    = {byte_data, asm_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                idx_d   = '0;
                state_d = (rem_q == CNT_ONE) ? S_DONE : S_RECV;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            asm_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            asm_q   <= asm_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    assign byte_ready = (state_q == S_RECV);
    assign we         = (state_q == S_WRITE);
    assign done       = (state_q == S_DONE);
    assign cpu_hold   = (state_q != S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign wa         = wa_q;
    assign wd         = wd_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory read port.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and issues single-cycle word writes to the instruction memory write port.
- Holds the CPU (cpu_hold) for the whole load session, then signals completion.
- Sits between the boot/debug byte source (e.g. UART RX) and the instruction memory.

Parameters:
- INS_ADDRESS, 9, byte-address width of the instruction memory. Depth is 2**(INS_ADDRESS-2) words.
- INS_W, 32, instruction word width. Only 32 is supported, i.e. 4 bytes per word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a load session; sampled only in IDLE.
- num_words  input  INS_ADDRESS-1  number of words to load; sampled with start.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  next instruction byte, least significant byte first.
- byte_ready  output  1  loader accepts a byte this cycle.
- we  output  1  instruction memory write enable, one-cycle pulse per word.
- wa  output  INS_ADDRESS  byte write address, word aligned (wa[1:0]=0).
- wd  output  INS_W  write data.
- cpu_hold  output  1  CPU must stall while high.
- busy  output  1  a session is in progress.
- done  output  1  one-cycle pulse at session end.

Behaviour:
- Reset (synchronous, active-high), all outputs 0:
  - State goes to IDLE.
  - Byte index, word address and remaining count are cleared.
  - The partial word is discarded.
  - Reset mid-session aborts immediately. Words already written stay in memory.
  - Reset has priority over every other input.
- Handshake: a byte is transferred in any cycle where byte_valid && byte_ready. byte_data is ignored otherwise.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready=0, cpu_hold=0, busy=0.
  - On start: load remaining = min(num_words, 2**(INS_ADDRESS-2)), set word address to 0 and byte index to 0.
  - If remaining==0, go to DONE; otherwise go to RECV.
- RECV:
  - byte_ready=1, cpu_hold=1, busy=1.
  - An accepted byte k (k=0..3) is stored in bits [8k+7:8k] of the assembly register, then the byte index increments.
  - Accepting byte 3 goes to WRITE on the next edge.
  - Gaps in byte_valid are allowed for any length.
- WRITE (exactly one cycle):
  - we=1, wa=current word address, wd=assembled word, byte_ready=0.
  - Next edge: address += 4, remaining -= 1, byte index = 0.
  - Go to DONE if remaining was 1, otherwise go to RECV.
- DONE (exactly one cycle):
  - done=1, cpu_hold=1, busy=1, then go to IDLE.
  - cpu_hold deasserts on the cycle after done.
- start is ignored outside IDLE.
- Outputs are registered or derived purely from state.
  - wa and wd hold their last values outside WRITE; only we qualifies them.
- Throughput: at least 5 cycles per word (4 accept cycles + 1 WRITE).
- Latency:
  - Last byte accepted to we: 1 cycle.
  - we to done: 1 cycle, when it was the last word.
- Address wrap is impossible because of the clamp. The final write of a full-depth load is at wa = 2**INS_ADDRESS - 4.
- num_words values above the depth are clamped, never wrapped.

Test Plan:
1. start, num_words=1; bytes 33,70,00,00 on consecutive cycles.
   -> byte_ready drops after the 4th byte; we=1 for one cycle with wa=0x000, wd=0x00007033; done pulses the next cycle; cpu_hold falls the cycle after.
2. num_words=2; bytes 33,70,00,00,93,00,10,00 with byte_valid low for 3 cycles between bytes.
   -> writes (0x000, 0x00007033) then (0x004, 0x00100093); byte_ready=0 during each WRITE cycle; exactly 2 we pulses.
3. start with num_words=0.
   -> no we; done=1 on the cycle after start; busy and cpu_hold high only during the DONE cycle.
4. num_words=200 with a continuous byte stream.
   -> exactly 128 we pulses; wa runs 0x000..0x1FC in steps of 4; single done pulse.
5. reset asserted for 1 cycle after 2 bytes of word 1.
   -> next cycle all outputs are 0 and no we occurs. A new start with bytes 13,05,10,00 writes wa=0x000, wd=0x00100513.
6. start pulsed again mid-session (word 1 of 2).
   -> ignored; the session completes with exactly 2 writes and 1 done.
